// File: rtl/dkong_dl_ctrl.sv
// -----------------------------------------------------------------------------
// dkong_dl_ctrl
//   ROM download controller for the Donkey Kong core. It watches the HPS ioctl
//   byte stream, forwards in-range bytes to the core ROMs one cycle late with a
//   one-hot region select, and keeps a byte count, a mod-256 checksum and an
//   out-of-range flag for each load. It also sequences the core reset: the
//   core is held in reset until a load has finished and a settle period has
//   elapsed, and a user reset request replays the settle period.
//
//   Handshake: ioctl_wr is a one-cycle strobe with no back-pressure; a byte is
//   taken whenever ioctl_download=1 and ioctl_wr=1 while a load is active
//   (including the cycle that starts the load). dn_wr is likewise a
//   one-cycle strobe; dn_addr/dn_data/dn_region are only meaningful with it.
//
// Ports
//   clk_sys        in   system clock
//   reset          in   synchronous active-high reset
//   ioctl_download in   download in progress
//   ioctl_wr       in   byte strobe
//   ioctl_addr     in   [24:0] byte address
//   ioctl_dout     in   [7:0]  byte data
//   user_reset     in   level reset request from OSD/button
//   core_reset     out  reset to the game core (low only in RUN)
//   dn_wr          out  ROM write strobe
//   dn_addr        out  [18:0] ROM address
//   dn_data        out  [7:0]  ROM data
//   dn_region      out  [4:0]  one-hot ROM region, zero when dn_wr=0
//   byte_cnt       out  [16:0] accepted in-range bytes this/last load
//   checksum       out  [7:0]  mod-256 sum of accepted bytes
//   range_err      out  sticky out-of-range flag for this load
//   load_ok        out  last load complete and error-free
//   o_dbg_state    out  [1:0]  FSM state (0 IDLE, 1 LOAD, 2 SETTLE, 3 RUN)
// -----------------------------------------------------------------------------
module dkong_dl_ctrl #(
  parameter int          SETTLE_CYC = 16,
  parameter logic [16:0] EXPECT_LEN = 17'h09300
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        core_reset,
  output logic        dn_wr,
  output logic [18:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [4:0]  dn_region,
  output logic [16:0] byte_cnt,
  output logic [7:0]  checksum,
  output logic        range_err,
  output logic        load_ok,
  output logic [1:0]  o_dbg_state
);

  localparam int          CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) + 1 : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [24:0] ROM_TOP     = 25'h09300;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_settle_cnt;
  // Set by reset: a download still asserted across a reset must drop before a
  // new load can start.
  logic          r_need_fall;

  logic          w_enter_load;
  logic          w_accept;
  logic          w_in_range;
  logic          w_wr_ok;
  logic [4:0]    w_region;
  logic [16:0]   w_cnt_base;
  logic [7:0]    w_sum_base;
  logic          w_err_base;

  assign o_dbg_state = r_state;

  // A load starts in the cycle download is seen from any non-LOAD state,
  // except IDLE while waiting for a fresh download assertion.
  assign w_enter_load = ioctl_download &&
                        (((r_state == S_IDLE) && !r_need_fall) ||
                         (r_state == S_RUN) || (r_state == S_SETTLE));
  assign w_accept     = ioctl_download && ioctl_wr &&
                        ((r_state == S_LOAD) || w_enter_load);
  assign w_in_range   = (ioctl_addr < ROM_TOP);
  assign w_wr_ok      = w_accept && w_in_range;

  // Statistics restart from zero in the entry cycle so a byte arriving in
  // that same cycle lands on top of the cleared values.
  assign w_cnt_base   = w_enter_load ? 17'd0 : byte_cnt;
  assign w_sum_base   = w_enter_load ? 8'd0  : checksum;
  assign w_err_base   = w_enter_load ? 1'b0  : range_err;

  always_comb begin
    w_region = 5'b00000;
    if (ioctl_addr < 25'h04000)      w_region = 5'b00001;  // main CPU
    else if (ioctl_addr < 25'h06000) w_region = 5'b00010;  // sound CPU
    else if (ioctl_addr < 25'h07000) w_region = 5'b00100;  // tiles
    else if (ioctl_addr < 25'h09000) w_region = 5'b01000;  // sprites
    else if (ioctl_addr < ROM_TOP)   w_region = 5'b10000;  // PROMs
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_need_fall  <= 1'b1;
      core_reset   <= 1'b1;
      dn_wr        <= 1'b0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_region    <= '0;
      byte_cnt     <= '0;
      checksum     <= '0;
      range_err    <= 1'b0;
      load_ok      <= 1'b0;
    end else begin
      // ROM write path
      dn_wr     <= 1'b0;
      dn_region <= 5'b00000;
      if (w_wr_ok) begin
        dn_wr     <= 1'b1;
        dn_addr   <= ioctl_addr[18:0];
        dn_data   <= ioctl_dout;
        dn_region <= w_region;
      end

      // Load statistics
      if (w_wr_ok && (w_cnt_base != 17'h1FFFF)) byte_cnt <= w_cnt_base + 17'd1;
      else                                      byte_cnt <= w_cnt_base;
      checksum  <= w_wr_ok ? (w_sum_base + ioctl_dout) : w_sum_base;
      range_err <= w_err_base | (w_accept && !w_in_range);

      if (!ioctl_download) r_need_fall <= 1'b0;

      // Sequencer; core_reset is low only while staying in or entering RUN.
      core_reset <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_enter_load) begin
            r_state <= S_LOAD;
            load_ok <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!ioctl_download) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
            load_ok      <= (byte_cnt == EXPECT_LEN) && !range_err;
          end
        end
        S_SETTLE: begin
          if (ioctl_download) begin
            r_state <= S_LOAD;
            load_ok <= 1'b0;
          end else if (user_reset) begin
            r_settle_cnt <= SETTLE_LOAD;
          end else if (r_settle_cnt == '0) begin
            r_state    <= S_RUN;
            core_reset <= 1'b0;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (ioctl_download) begin
            r_state <= S_LOAD;
            load_ok <= 1'b0;
          end else if (user_reset) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
          end else begin
            core_reset <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dkong_dl_ctrl.md
DKONG_DL_CTRL -- requirements
Module: dkong_dl_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: cycles core_reset stays high after a load or user reset ends.
REQ-002 SHALL have parameter EXPECT_LEN, default 17'h09300: byte count of a complete ROM image.
REQ-003 SHALL have port clk_sys  in  1  system clock; the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high block reset.
REQ-005 SHALL have port ioctl_download  in  1  HPS download in progress.
REQ-006 SHALL have port ioctl_wr  in  1  one-cycle byte strobe from HPS.
REQ-007 SHALL have port ioctl_addr  in  25  HPS byte address.
REQ-008 SHALL have port ioctl_dout  in  8  HPS byte data.
REQ-009 SHALL have port user_reset  in  1  OSD or button reset request (level).
REQ-010 SHALL have port core_reset  out  1  active-high reset to the game core.
REQ-011 SHALL have port dn_wr  out  1  registered write strobe to the core ROMs.
REQ-012 SHALL have port dn_addr  out  19  registered ROM address.
REQ-013 SHALL have port dn_data  out  8  registered ROM data.
REQ-014 SHALL have port dn_region  out  5  one-hot region select, valid with dn_wr.
REQ-015 SHALL have port byte_cnt  out  17  accepted bytes in the current or last load.
REQ-016 SHALL have port checksum  out  8  mod-256 sum of accepted bytes.
REQ-017 SHALL have port range_err  out  1  sticky flag: an out-of-range write occurred this load.
REQ-018 SHALL have port load_ok  out  1  last load was complete and error-free.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, SETTLE, RUN.
REQ-020 IDLE SHALL be entered on reset, SHALL hold core_reset=1, and SHALL go to LOAD when ioctl_download=1.
REQ-021 RUN SHALL go to LOAD when ioctl_download=1.
REQ-022 On every entry to LOAD, byte_cnt, checksum, range_err and load_ok SHALL clear to 0 in the entry cycle.
REQ-023 LOAD SHALL go to SETTLE on the first cycle with ioctl_download=0.
REQ-024 On LOAD exit, load_ok SHALL be set to 1 iff byte_cnt==EXPECT_LEN and range_err==0.
REQ-025 SETTLE SHALL load a counter with SETTLE_CYC-1 on entry, decrement it each cycle, and go to RUN in the cycle after it reaches 0.
REQ-026 core_reset SHALL be 1 in IDLE, LOAD and SETTLE, and 0 only in RUN.
REQ-027 In RUN, user_reset=1 SHALL cause a transition to SETTLE, reasserting core_reset the next cycle.
REQ-028 In SETTLE, user_reset=1 SHALL reload the counter to SETTLE_CYC-1.
REQ-029 In LOAD and IDLE, user_reset SHALL be ignored.
REQ-030 ioctl_download=1 in the same cycle as user_reset SHALL take priority and cause a transition to LOAD.
REQ-031 A write SHALL be accepted when ioctl_download=1 and ioctl_wr=1, including the cycle ioctl_download first rises; that byte SHALL count after the clear (byte_cnt=1).
REQ-032 An accepted write SHALL be in range iff ioctl_addr<25'h09300.
REQ-033 Address regions SHALL map as: bit0 = 0x00000-0x03FFF main CPU; bit1 = 0x04000-0x05FFF sound CPU; bit2 = 0x06000-0x06FFF tiles; bit3 = 0x07000-0x08FFF sprites; bit4 = 0x09000-0x092FF PROMs.
REQ-034 For an in-range accepted write, dn_wr SHALL pulse exactly 1 cycle, 1 cycle after ioctl_wr, with dn_addr=ioctl_addr[18:0], dn_data=ioctl_dout and the matching dn_region.
REQ-035 For an in-range accepted write, byte_cnt SHALL increment saturating at 17'h1FFFF, and checksum SHALL add the byte mod 256.
REQ-036 An out-of-range write SHALL produce no dn_wr, SHALL not change byte_cnt or checksum, and SHALL set range_err.
REQ-037 dn_region SHALL be 0 whenever dn_wr=0.
REQ-038 dn_addr and dn_data SHALL hold their last values while dn_wr=0.
REQ-039 A write with ioctl_wr=1 and ioctl_download=0 SHALL be ignored.
REQ-040 A new download started from SETTLE SHALL go to LOAD immediately and abandon the settle count.

Reset
REQ-041 reset=1 SHALL force IDLE, core_reset=1, dn_wr=0, dn_region=0, dn_addr=0, dn_data=0, byte_cnt=0, checksum=0, range_err=0, load_ok=0 on the next clock edge, overriding all other inputs.
REQ-042 reset during LOAD SHALL abort the load, with load_ok=0, and a new load SHALL require a fresh ioctl_download assertion.

Verification
REQ-043 Full load: stream 0x9300 bytes, all 0x01, addr 0..0x92FF -> 0x9300 dn_wr pulses, each 1 cycle late; byte_cnt=0x9300; checksum=0x00; load_ok=1; core_reset falls 16 cycles after download drops.
REQ-044 Region decode: writes at 0x03FFF, 0x04000, 0x06FFF, 0x07000, 0x092FF -> dn_region = 00001, 00010, 00100, 01000, 10000.
REQ-045 Out of range: a write at 0x09300 inside a full load -> no dn_wr; range_err=1; byte_cnt=0x9300; load_ok=0.
REQ-046 User reset: in RUN pulse user_reset 1 cycle -> core_reset=1 next cycle, then 0 after 16 cycles; repeat user_reset at settle count 5 -> count restarts.
REQ-047 Reset mid-load: assert reset after 100 bytes -> IDLE; all outputs at reset values; core_reset stays 1 until a new download completes plus 16 cycles.
REQ-048 Edge write: ioctl_wr high in the first download cycle -> byte_cnt=1 and dn_wr pulses; ioctl_wr with download low -> ignored.
